// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - state encoding and default parameters shared by pc_sequencer and return_stack
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } seq_state_t;

    localparam logic [31:0] DEFAULT_RESET_IP  = 32'h0000_0000;
    localparam int          DEFAULT_RAS_DEPTH = 4;

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - circular return-address stack; a push when full overwrites the oldest entry
module return_stack
    import pc_seq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_RAS_DEPTH
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [CW-1:0] count;
    logic [PW-1:0] top_idx;
    logic          full;

    assign top_idx = ptr - PW'(1);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign top     = mem[top_idx];

    // Pop-then-push on a non-empty stack collapses to rewriting the top entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (pop && push && !empty) begin
            mem[top_idx] <= push_data;
        end else if (push) begin
            mem[ptr] <= push_data;
            ptr      <= ptr + PW'(1);
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr   <= top_idx;
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch IP sequencer with branch redirect, flush and halt
// Optional return-address stack enabled by defining PC_SEQ_RAS_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_IP  = DEFAULT_RESET_IP,
    parameter int          RAS_DEPTH = DEFAULT_RAS_DEPTH
) (
    input  logic        clock,
    input  logic        reset,
    output logic        io_fetch_valid,
    input  logic        io_fetch_ready,
    output logic [31:0] io_fetch_ip,
    input  logic        io_stall,
    input  logic        io_br_valid,
    input  logic        io_br_taken,
    input  logic [31:0] io_br_ip,
    input  logic [31:0] io_br_imm,
    input  logic        io_call,
    input  logic        io_ret,
    input  logic        io_halt,
    output logic        io_flush,
    output logic        io_halted
);

    seq_state_t  state, state_next;
    logic [31:0] ip, ip_next;
    logic [31:0] target, offset_target;
    logic        taken, redirect;

    assign taken         = io_br_valid & io_br_taken;
    assign offset_target = io_br_ip + io_br_imm;
    // A taken branch only redirects while the front end is live and not halting.
    assign redirect      = taken & ~io_halt & ((state == FETCH) | (state == REDIRECT));
    assign io_flush      = redirect;
    assign io_fetch_ip   = ip;

`ifdef PC_SEQ_RAS_EN
    logic        ras_empty;
    logic [31:0] ras_top;

    assign target = (io_ret && !ras_empty) ? ras_top : offset_target;

    return_stack #(
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clock    (clock),
        .reset    (reset),
        .push     (redirect & io_call),
        .pop      (redirect & io_ret),
        .push_data(io_br_ip + 32'd1),
        .top      (ras_top),
        .empty    (ras_empty)
    );
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic          unused_ras;

    assign unused_ras = io_call ^ io_ret;
    assign target     = offset_target;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
            ip    <= RESET_IP;
        end else begin
            state <= state_next;
            ip    <= ip_next;
        end
    end

    always_comb begin
        state_next     = state;
        ip_next        = ip;
        io_fetch_valid = 1'b0;
        io_halted      = 1'b0;
        unique case (state)
            BOOT: begin
                state_next = FETCH;
            end
            FETCH: begin
                io_fetch_valid = 1'b1;
                if (io_halt) begin
                    state_next = HALT;
                end else if (taken) begin
                    ip_next    = target;
                    state_next = REDIRECT;
                end else if (io_fetch_ready && !io_stall) begin
                    ip_next = ip + 32'd1;
                end
            end
            REDIRECT: begin
                if (io_halt) begin
                    state_next = HALT;
                end else if (taken) begin
                    ip_next = target;
                end else begin
                    state_next = FETCH;
                end
            end
            HALT: begin
                io_halted = 1'b1;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

endmodule
